lcd_src_sched: RTL



---
 rtl/lcd_pkg.sv | 18 +
 rtl/lcd_src_sched_sw_debounce.sv | 45 ++++
 rtl/lcd_src_sched.sv | 122 ++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD display path.
//   lcd_src_state_e : pixel-source scheduler states
//   H/V_ACTIVE_DEF  : default active raster size of the 800x480 panel
//   PIX_BLACK       : pixel value emitted during blank frames
package lcd_pkg;

    typedef enum logic [1:0] {
        SHOW_UI      = 2'd0,
        BLANK_TO_IMG = 2'd1,
        SHOW_IMG     = 2'd2,
        BLANK_TO_UI  = 2'd3
    } lcd_src_state_e;

    localparam int          H_ACTIVE_DEF = 800;
    localparam int          V_ACTIVE_DEF = 480;
    localparam logic [23:0] PIX_BLACK    = 24'h000000;

endpackage

// File: rtl/lcd_src_sched_sw_debounce.sv
// sw_debounce: 2-FF synchroniser followed by a stability filter.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : raw asynchronous input
//   dout       : filtered level; follows din once the synchronised value has
//                differed from dout for DEBOUNCE_CYC consecutive cycles
// Latency from a clean din edge to dout is 2 + DEBOUNCE_CYC cycles.
module sw_debounce #(
    parameter int DEBOUNCE_CYC = 330000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic          sync1_q, sync2_q, dout_q;
    logic [CW-1:0] cnt_q;

    // Counting only while the synchronised input disagrees with dout; any
    // return to agreement (i.e. a bounce) clears the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            if (sync2_q == dout_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                dout_q <= sync2_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/lcd_src_sched.sv
// lcd_src_sched: frame-synchronous pixel-source scheduler (UI vs image).
//   lcd_clk_33m, rst_n          : pixel clock, asynchronous active-low reset
//   mode_sw                     : raw switch, 1 = image requested
//   calc_done                   : one-cycle pulse, forces UI for HOLD_FRAMES
//   pix_x, pix_y                : raster position from the LCD controller
//   pix_data_ui, pix_data_img   : candidate pixels
//   pix_data                    : selected pixel (black while blanking)
//   src_sel                     : 0 = UI, 1 = image
//   blanking, busy              : high during black transition frames
//   frame_end                   : high on the last active pixel of a frame
// Source changes only on the edge closing a frame_end cycle, so every frame
// comes from a single source.
module lcd_src_sched
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int DEBOUNCE_CYC = 330000,
    parameter int BLANK_FRAMES = 2,
    parameter int HOLD_FRAMES  = 60
) (
    input  logic        lcd_clk_33m,
    input  logic        rst_n,
    input  logic        mode_sw,
    input  logic        calc_done,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    input  logic [23:0] pix_data_ui,
    input  logic [23:0] pix_data_img,
    output logic [23:0] pix_data,
    output logic        src_sel,
    output logic        blanking,
    output logic        frame_end,
    output logic        busy
);

    localparam int HW = (HOLD_FRAMES  > 0) ? $clog2(HOLD_FRAMES + 1)  : 1;
    localparam int BW = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;

    logic           sw_db;
    logic           want_img;
    lcd_src_state_e state_q, state_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [BW-1:0]  blank_cnt_q, blank_cnt_d;

    sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sw_debounce (
        .clk   (lcd_clk_33m),
        .rst_n (rst_n),
        .din   (mode_sw),
        .dout  (sw_db)
    );

    assign frame_end = (pix_x == 11'(H_ACTIVE - 1)) && (pix_y == 11'(V_ACTIVE - 1));

    // calc_done vetoes the image in its own cycle so a pulse coinciding with
    // frame_end already starts the change back to UI.
    assign want_img = sw_db && (hold_cnt_q == '0) && !calc_done;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (calc_done)
            hold_cnt_d = HW'(HOLD_FRAMES);
        else if (frame_end && (hold_cnt_q != '0))
            hold_cnt_d = hold_cnt_q - 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        if (frame_end) begin
            case (state_q)
                SHOW_UI: if (want_img) begin
                    if (BLANK_FRAMES == 0) begin
                        state_d = SHOW_IMG;
                    end else begin
                        state_d     = BLANK_TO_IMG;
                        blank_cnt_d = BW'(BLANK_FRAMES);
                    end
                end
                BLANK_TO_IMG: begin
                    if (!want_img)                 state_d = SHOW_UI;
                    else if (blank_cnt_q == BW'(1)) state_d = SHOW_IMG;
                    else                           blank_cnt_d = blank_cnt_q - 1'b1;
                end
                SHOW_IMG: if (!want_img) begin
                    if (BLANK_FRAMES == 0) begin
                        state_d = SHOW_UI;
                    end else begin
                        state_d     = BLANK_TO_UI;
                        blank_cnt_d = BW'(BLANK_FRAMES);
                    end
                end
                BLANK_TO_UI: begin
                    if (want_img)                  state_d = SHOW_IMG;
                    else if (blank_cnt_q == BW'(1)) state_d = SHOW_UI;
                    else                           blank_cnt_d = blank_cnt_q - 1'b1;
                end
                default: state_d = SHOW_UI;
            endcase
        end
    end

    always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SHOW_UI;
            hold_cnt_q  <= '0;
            blank_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    // Outputs decode the registered state only, so an asynchronous reset
    // takes effect on the pixel path immediately.
    assign src_sel  = (state_q == SHOW_IMG) || (state_q == BLANK_TO_UI);
    assign blanking = (state_q == BLANK_TO_IMG) || (state_q == BLANK_TO_UI);
    assign busy     = blanking;
    assign pix_data = blanking ? PIX_BLACK : (src_sel ? pix_data_img : pix_data_ui);

endmodule
